// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: turns framed UART bytes into single 32-bit bus transfers
// and streams a status (plus read data) response back over the UART.
//
// Frame:    opcode, addr[31:24], addr[23:16], addr[15:8], addr[7:0]
//           opcode 0x57 (write) appends wdata bytes, MSB first
//           opcode 0x52 (read) has no payload
// Response: status (0x00 ok, 0x01 bus error, 0x02 bad opcode);
//           reads follow the status with 4 data bytes, MSB first
//           (all zero when the bus reported an error).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rxData, rxDone        received byte and its one-cycle strobe
//   txData, txValid       byte to transmit and its one-cycle start strobe
//   txDone                transmitter finished the outstanding byte
//   addr, wdata, strobe   bus request, held stable while wen/ren is high
//   wen, ren              bus write/read request
//   rdata, request_stall  bus read data, stall (hold the request)
//   error                 bus error, sampled on the completing cycle
//   busy                  high whenever the FSM is not idle
//   overrun               sticky: a byte arrived while in BUS or RESP
//   dbg_state_o           current FSM state (0 IDLE .. 4 RESP)
//
// Handshakes: rxDone, txValid and txDone are single-cycle strobes; exactly
// one byte is outstanding between a txValid and the following txDone.
// A bus request completes on the first cycle with request_stall low.
//
// Optional build macro UART_BUS_BRIDGE_TIMEOUT_EN: abandon a partial frame
// (back to IDLE, no bus access, no response) when no byte arrives for
// TIMEOUT_CYCLES-1 cycles while in ADDR or DATA.
module uart_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rxData,
  input  logic        rxDone,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txDone,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  strobe,
  output logic        wen,
  output logic        ren,
  input  logic [31:0] rdata,
  input  logic        request_stall,
  input  logic        error,
  output logic        busy,
  output logic        overrun,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_BUS   = 8'h01;
  localparam logic [7:0] ST_BAD   = 8'h02;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_bus_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state_q;
  logic [1:0]  cnt_q;          // byte index inside ADDR/DATA/RESP data phase
  logic        is_write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strobe_q;
  logic        wen_q;
  logic        ren_q;
  logic [31:0] rdata_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        tx_pending_q;   // a byte has been launched, waiting for txDone
  logic        send_data_q;    // response carries 4 data bytes after status
  logic        resp_data_q;    // status byte done, now in the data bytes
  logic        overrun_q;
  logic [7:0]  resp_byte;

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
  // The counter is 0 on the cycle after a byte; matching TIMEOUT_CYCLES-2
  // means the transition lands as the count reaches TIMEOUT_CYCLES-1.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 2);
  logic [31:0] to_q;
`endif

  always_comb begin
    resp_byte = 8'h00;
    case (cnt_q)
      2'd0:    resp_byte = rdata_q[31:24];
      2'd1:    resp_byte = rdata_q[23:16];
      2'd2:    resp_byte = rdata_q[15:8];
      default: resp_byte = rdata_q[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      is_write_q   <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      strobe_q     <= 4'h0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      rdata_q      <= 32'h0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      tx_pending_q <= 1'b0;
      send_data_q  <= 1'b0;
      resp_data_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
      to_q         <= 32'h0;
`endif
    end else begin
      tx_valid_q <= 1'b0;
      if (rxDone && (state_q == S_BUS || state_q == S_RESP)) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          cnt_q       <= 2'd0;
          resp_data_q <= 1'b0;
          if (rxDone) begin
            if (rxData == OP_READ || rxData == OP_WRITE) begin
              is_write_q <= (rxData == OP_WRITE);
              state_q    <= S_ADDR;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
              to_q       <= 32'h0;
`endif
            end else begin
              // Bad opcode: launch the status byte on the way into RESP.
              send_data_q  <= 1'b0;
              tx_data_q    <= ST_BAD;
              tx_valid_q   <= 1'b1;
              tx_pending_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rxDone) begin
            addr_q <= {addr_q[23:0], rxData};
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
            to_q   <= 32'h0;
`endif
            if (cnt_q == 2'd3) begin
              cnt_q <= 2'd0;
              if (is_write_q) begin
                state_q <= S_DATA;
              end else begin
                state_q  <= S_BUS;
                ren_q    <= 1'b1;
                strobe_q <= 4'hF;
              end
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            to_q    <= 32'h0;
          end else begin
            to_q <= to_q + 32'h1;
          end
`endif
        end

        S_DATA: begin
          if (rxDone) begin
            wdata_q <= {wdata_q[23:0], rxData};
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
            to_q    <= 32'h0;
`endif
            if (cnt_q == 2'd3) begin
              cnt_q    <= 2'd0;
              state_q  <= S_BUS;
              wen_q    <= 1'b1;
              strobe_q <= 4'hF;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            to_q    <= 32'h0;
          end else begin
            to_q <= to_q + 32'h1;
          end
`endif
        end

        S_BUS: begin
          if (!request_stall) begin
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            strobe_q     <= 4'h0;
            rdata_q      <= (error || is_write_q) ? 32'h0 : rdata;
            send_data_q  <= !is_write_q;
            resp_data_q  <= 1'b0;
            cnt_q        <= 2'd0;
            tx_data_q    <= error ? ST_BUS : ST_OK;
            tx_valid_q   <= 1'b1;
            tx_pending_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end

        S_RESP: begin
          if (tx_pending_q) begin
            if (txDone) begin
              tx_pending_q <= 1'b0;
              if (!resp_data_q) begin
                if (send_data_q) resp_data_q <= 1'b1;
                else             state_q     <= S_IDLE;
              end else if (cnt_q == 2'd3) begin
                cnt_q   <= 2'd0;
                state_q <= S_IDLE;
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end
          end else begin
            // Previous byte acknowledged last cycle: launch the next one.
            tx_data_q    <= resp_byte;
            tx_valid_q   <= 1'b1;
            tx_pending_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign txData      = tx_data_q;
  assign txValid     = tx_valid_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign strobe      = strobe_q;
  assign wen         = wen_q;
  assign ren         = ren_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;

  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxDone = 1'b0;
  logic [7:0]  txData;
  logic        txValid;
  logic        txDone = 1'b0;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic        wen;
  logic        ren;
  logic [31:0] rdata = 32'h0;
  logic        request_stall = 1'b0;
  logic        error = 1'b0;
  logic        busy;
  logic        overrun;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // scoreboard: expected and observed response bytes
  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];

  int wen_cycles = 0;
  int ren_cycles = 0;
  int tx_viol = 0;
  int stall_left = 0;
  logic [31:0] seen_addr = 32'h0;
  logic [31:0] seen_wdata = 32'h0;
  logic [3:0]  seen_strobe = 4'h0;

  uart_bus_bridge #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .rxData(rxData), .rxDone(rxDone),
    .txData(txData), .txValid(txValid), .txDone(txDone),
    .addr(addr), .wdata(wdata), .strobe(strobe), .wen(wen), .ren(ren),
    .rdata(rdata), .request_stall(request_stall), .error(error),
    .busy(busy), .overrun(overrun), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // bus monitor and stall generator, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (wen === 1'b1) begin
        wen_cycles++;
        seen_addr   = addr;
        seen_wdata  = wdata;
        seen_strobe = strobe;
      end
      if (ren === 1'b1) begin
        ren_cycles++;
        seen_addr   = addr;
        seen_strobe = strobe;
      end
      if ((wen === 1'b1 || ren === 1'b1) && stall_left > 0) begin
        request_stall = 1'b1;
        stall_left--;
      end else begin
        request_stall = 1'b0;
      end
    end
  end

  // UART transmitter model: accepts a byte, acks it 3 cycles later, and
  // flags any txValid that arrives while a byte is still outstanding.
  initial begin
    forever begin
      @(negedge clk);
      if (txValid === 1'b1) begin
        act_q.push_back(txData);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (txValid === 1'b1) tx_viol++;
        end
        txDone = 1'b1;
        @(negedge clk);
        if (txValid === 1'b1) tx_viol++;
        txDone = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one rxDone strobe per byte; entered and left at posedge+1
  task automatic send_byte(input logic [7:0] b);
    rxData = b;
    rxDone = 1'b1;
    @(posedge clk); #1;
    rxDone = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(busy), 32'h0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    act_q.delete();
    exp_q.delete();
    wen_cycles = 0;
    ren_cycles = 0;
    tx_viol = 0;
  endtask

  task automatic check_resp(input string tag);
    chk({tag, "_resp_len"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) chk($sformatf("%s_resp_byte%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
    end
    chk({tag, "_tx_spacing"}, 32'(tx_viol), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // reset values
    chk("rst_txValid", 32'(txValid), 32'h0);
    chk("rst_wen", 32'(wen), 32'h0);
    chk("rst_ren", 32'(ren), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_txData", 32'(txData), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_strobe", 32'(strobe), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);

    // write, no stall
    clear_obs();
    stall_left = 0;
    send_byte(8'h57);
    chk("wr_busy", 32'(busy), 32'h1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h14); send_byte(8'h45);
    wait_idle("wr");
    chk("wr_wen_cycles", 32'(wen_cycles), 32'd1);
    chk("wr_ren_cycles", 32'(ren_cycles), 32'd0);
    chk("wr_addr", seen_addr, 32'h0000000C);
    chk("wr_wdata", seen_wdata, 32'h00001445);
    chk("wr_strobe", 32'(seen_strobe), 32'hF);
    exp_q.push_back(8'h00);
    check_resp("wr");

    // read with 3 stall cycles
    clear_obs();
    stall_left = 3;
    rdata = 32'hA5A5003C;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    chk("rd_ren_now", 32'(ren), 32'h1);
    chk("rd_state_bus", 32'(dbg_state), 32'd3);
    wait_idle("rd");
    chk("rd_ren_cycles", 32'(ren_cycles), 32'd4);
    chk("rd_wen_cycles", 32'(wen_cycles), 32'd0);
    chk("rd_addr", seen_addr, 32'h00000004);
    chk("rd_strobe", 32'(seen_strobe), 32'hF);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00); exp_q.push_back(8'h3C);
    check_resp("rd");

    // read with bus error
    clear_obs();
    stall_left = 0;
    rdata = 32'hDEADBEEF;
    error = 1'b1;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    wait_idle("rderr");
    error = 1'b0;
    chk("rderr_ren_cycles", 32'(ren_cycles), 32'd1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    check_resp("rderr");

    // bad opcode, then a valid read
    clear_obs();
    send_byte(8'h13);
    chk("bad_state_resp", 32'(dbg_state), 32'd4);
    wait_idle("bad");
    chk("bad_wen_cycles", 32'(wen_cycles), 32'd0);
    chk("bad_ren_cycles", 32'(ren_cycles), 32'd0);
    chk("bad_state_idle", 32'(dbg_state), 32'd0);
    exp_q.push_back(8'h02);
    check_resp("bad");
    chk("bad_overrun", 32'(overrun), 32'h0);

    clear_obs();
    rdata = 32'h12345678;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    wait_idle("rd2");
    chk("rd2_ren_cycles", 32'(ren_cycles), 32'd1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    check_resp("rd2");

    // byte arriving during RESP sets overrun, response unchanged
    clear_obs();
    rdata = 32'h0BADF00D;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    @(posedge clk); #1;
    chk("ovr_state_resp", 32'(dbg_state), 32'd4);
    send_byte(8'h57);
    chk("ovr_set", 32'(overrun), 32'h1);
    wait_idle("ovr");
    exp_q.push_back(8'h00); exp_q.push_back(8'h0B); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    check_resp("ovr");
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // reset in the middle of a stalled bus read
    clear_obs();
    stall_left = 1000;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    repeat (2) @(posedge clk);
    #1;
    chk("rstbus_ren_before", 32'(ren), 32'h1);
    reset = 1'b1;
    #1;
    chk("rstbus_ren", 32'(ren), 32'h0);
    chk("rstbus_busy", 32'(busy), 32'h0);
    chk("rstbus_overrun", 32'(overrun), 32'h0);
    stall_left = 0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rstbus_no_tx", 32'(act_q.size()), 32'd0);

    // partial frame then silence
    clear_obs();
    send_byte(8'h52);
    send_byte(8'h00);
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    repeat (TO_CYC - 2) @(posedge clk);
    #1;
    chk("to_still_addr", 32'(dbg_state), 32'd1);
    @(posedge clk); #1;
    chk("to_idle", 32'(dbg_state), 32'd0);
    chk("to_busy", 32'(busy), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("to_no_tx", 32'(act_q.size()), 32'd0);
    chk("to_no_bus", 32'(ren_cycles + wen_cycles), 32'd0);
`else
    repeat (3 * TO_CYC) @(posedge clk);
    #1;
    chk("noto_still_addr", 32'(dbg_state), 32'd1);
    chk("noto_busy", 32'(busy), 32'h1);
    chk("noto_no_tx", 32'(act_q.size()), 32'd0);
    do_reset();
    chk("noto_idle_after_rst", 32'(dbg_state), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
